imm_decode_stage: RTL and testbench
===================================

Name: imm_decode_stage

Overview:
Registered successor to the combinational immediate-select decoder. It accepts a 32-bit instruction over a valid/ready handshake, classifies the opcode, and produces both immSrc and the fully sign-extended XLEN immediate. It also flags illegal opcodes and keeps a saturating illegal-instruction count. It sits between the instruction register and the register-file/ALU-source logic, as a one-entry pipeline stage.

Parameters:
XLEN, 32, datapath width of the extended immediate (32 or 64).
CNT_W, 8, width of the illegal-instruction counter.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
flush  input  1  synchronous drop of held entry
in_valid  input  1  instruction offered
in_ready  output  1  stage can accept
in_instr  input  32  instruction word
out_valid  output  1  decoded entry held
out_ready  input  1  consumer accepts
out_instr  output  32  registered copy of instruction
out_immSrc  output  3  000 I, 001 S, 010 B, 011 J, 100 U
out_imm  output  XLEN  sign-extended immediate
out_illegal  output  1  held entry has unsupported opcode
illegal_cnt  output  CNT_W  saturating count of accepted illegal entries

Behaviour:
- One clock (clk). Reset is synchronous, active-high (rst).
- Reset values: out_valid=0, out_instr=0, out_immSrc=000, out_imm=0, out_illegal=0, illegal_cnt=0.
- in_ready = !flush && (!out_valid || out_ready). This is combinational and has no path from in_valid.
- Accept: in_valid && in_ready. On the next edge, the output registers load the decode of in_instr and out_valid=1. Latency is 1 cycle. Throughput is 1 per cycle while out_ready=1.
- Drain: out_valid && out_ready with no accept gives out_valid=0 on the next edge. Data registers hold their values.
- Held entry with out_ready=0: all out_* stay stable. in_ready=0.
- flush=1: out_valid=0 on the next edge and no accept that cycle. A simultaneous in_valid is dropped. illegal_cnt is unaffected by the flush cycle.
- rst overrides flush and accept. Reset mid-transfer discards the entry.
- Opcode map (in_instr[6:0]):
  - 0000011 LOAD, I-type
  - 0100011 STORE, S-type
  - 0110011 R-type, immSrc 000
  - 0010011 OP-IMM, I-type
  - 1100011 BRANCH, B-type
  - 1101111 JAL, J-type
  - 0110111 LUI, U-type
  - 0010111 AUIPC, U-type
  - 1100111 JALR, I-type
- Any other opcode: out_illegal=1, out_immSrc=000, out_imm=0.
- Immediates, all sign-extended from in_instr[31] to XLEN:
  - I: [31:20]
  - S: {[31:25],[11:7]}
  - B: {[31],[7],[30:25],[11:8],1'b0}
  - J: {[31],[19:12],[20],[30:21],1'b0}
  - U: {[31:12],12'b0}. For XLEN=64, bits 63:32 are copies of bit 31.
- R-type: out_imm=0, out_illegal=0.
- illegal_cnt increments by 1 on each accept whose opcode is illegal. It saturates at 2^CNT_W-1 and never wraps. Only rst clears it.

Test Plan:
- Reset with rst=1 for 2 cycles, then in_valid=1, in_instr=0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_valid=1, out_immSrc=000, out_imm=0xFFFFFFFF, out_illegal=0.
- Back-to-back stream 0x00112623, 0xFE000EE3, 0x008000EF, 0x123452B7 with out_ready=1 and in_ready=1 every cycle -> in consecutive cycles (immSrc, imm) = (001, 0x0000000C), (010, 0xFFFFFFFC), (011, 0x00000008), (100, 0x12345000).
- Backpressure: accept 0x00112623, hold out_ready=0 for 3 cycles while offering 0x008000EF -> in_ready=0 and outputs frozen at 001/0x0000000C. Raise out_ready -> 0x008000EF is accepted that cycle and appears next with 011/0x00000008.
- Illegal: send in_instr=0x0000007F, then 0xFFFFFFFF -> out_illegal=1, out_imm=0, out_immSrc=000, illegal_cnt 0→1→2. With CNT_W=2, send 5 illegal words -> illegal_cnt sticks at 3.
- Flush: entry held with out_ready=0, assert flush with in_valid=1 -> in_ready=0, next cycle out_valid=0, the offered word is never output, illegal_cnt unchanged.
- XLEN=64: in_instr=0x800002B7 (lui x5,0x80000) -> out_imm=0xFFFFFFFF80000000. in_instr=0xFFF00093 -> out_imm=0xFFFFFFFFFFFFFFFF.

Source files
------------

// File: rtl/imm_decode_stage.sv
// One-entry registered decode stage: classifies the opcode, selects the immediate
// format, sign-extends the immediate to XLEN and keeps a saturating illegal-opcode count.
module imm_decode_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [2:0]       out_immSrc,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [2:0]      dec_src;
    logic [31:0]     dec_imm32;
    logic            dec_illegal;
    logic [XLEN-1:0] dec_imm;
    logic            accept;

    // Ready depends only on flush and the held entry, never on in_valid.
    assign in_ready = !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        dec_src     = IMM_I;
        dec_imm32   = 32'd0;
        dec_illegal = 1'b0;
        case (in_instr[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: begin
                dec_src   = IMM_I;
                dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            7'b0100011: begin
                dec_src   = IMM_S;
                dec_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            7'b1100011: begin
                dec_src   = IMM_B;
                dec_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                             in_instr[30:25], in_instr[11:8], 1'b0};
            end
            7'b1101111: begin
                dec_src   = IMM_J;
                dec_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                             in_instr[20], in_instr[30:21], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec_src   = IMM_U;
                dec_imm32 = {in_instr[31:12], 12'd0};
            end
            7'b0110011: begin
                dec_src   = IMM_I;
                dec_imm32 = 32'd0;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

    // Every 32-bit format already carries its sign in bit 31, so widening is uniform.
    generate
        if (XLEN > 32) begin : g_wide
            assign dec_imm = {{(XLEN-32){dec_imm32[31]}}, dec_imm32};
        end else begin : g_narrow
            assign dec_imm = dec_imm32[XLEN-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_instr   <= 32'd0;
            out_immSrc  <= 3'b000;
            out_imm     <= '0;
            out_illegal <= 1'b0;
            illegal_cnt <= '0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_instr   <= in_instr;
            out_immSrc  <= dec_src;
            out_imm     <= dec_imm;
            out_illegal <= dec_illegal;
            if (dec_illegal && (illegal_cnt != CNT_MAX)) begin
                illegal_cnt <= illegal_cnt + 1'b1;
            end
        end else if (flush || out_ready) begin
            // Data registers keep their last value once the entry leaves.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: default build plus CNT_W=2 and XLEN=64 variants
// driven by the same stimulus.
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        out_ready;

    logic        in_ready,  in_ready_c2,  in_ready_64;
    logic        out_valid, out_valid_c2, out_valid_64;
    logic [31:0] out_instr, out_instr_c2, out_instr_64;
    logic [2:0]  out_immSrc, out_immSrc_c2, out_immSrc_64;
    logic [31:0] out_imm, out_imm_c2;
    logic [63:0] out_imm_64;
    logic        out_illegal, out_illegal_c2, out_illegal_64;
    logic [7:0]  illegal_cnt, illegal_cnt_64;
    logic [1:0]  illegal_cnt_c2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    imm_decode_stage #(.XLEN(32), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_immSrc(out_immSrc), .out_imm(out_imm),
        .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
    );

    imm_decode_stage #(.XLEN(32), .CNT_W(2)) dut_c2 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_c2),
        .in_instr(in_instr), .out_valid(out_valid_c2), .out_ready(out_ready),
        .out_instr(out_instr_c2), .out_immSrc(out_immSrc_c2), .out_imm(out_imm_c2),
        .out_illegal(out_illegal_c2), .illegal_cnt(illegal_cnt_c2)
    );

    imm_decode_stage #(.XLEN(64), .CNT_W(8)) dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_64),
        .in_instr(in_instr), .out_valid(out_valid_64), .out_ready(out_ready),
        .out_instr(out_instr_64), .out_immSrc(out_immSrc_64), .out_imm(out_imm_64),
        .out_illegal(out_illegal_64), .illegal_cnt(illegal_cnt_64)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = 32'd0; out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic send(input logic [31:0] w);
        in_instr = w; in_valid = 1'b1; out_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        n_cmp++; if (out_instr !== 32'd0) begin n_bad++; $display("FAIL reset_instr got=%h want=0", out_instr); end
        n_cmp++; if (out_immSrc !== 3'b000) begin n_bad++; $display("FAIL reset_src got=%b want=000", out_immSrc); end
        n_cmp++; if (out_imm !== 32'd0) begin n_bad++; $display("FAIL reset_imm got=%h want=0", out_imm); end
        n_cmp++; if (out_illegal !== 1'b0) begin n_bad++; $display("FAIL reset_illegal got=%b want=0", out_illegal); end
        n_cmp++; if (illegal_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_cnt got=%0d want=0", illegal_cnt); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        $display("reset: valid=%b cnt=%0d", out_valid, illegal_cnt);
    endtask

    task automatic test_addi();
        send(32'hFFF00093);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL addi_valid got=%b want=1", out_valid); end
        n_cmp++; if (out_immSrc !== 3'b000) begin n_bad++; $display("FAIL addi_src got=%b want=000", out_immSrc); end
        n_cmp++; if (out_imm !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL addi_imm got=%h want=ffffffff", out_imm); end
        n_cmp++; if (out_illegal !== 1'b0) begin n_bad++; $display("FAIL addi_illegal got=%b want=0", out_illegal); end
        n_cmp++; if (out_instr !== 32'hFFF00093) begin n_bad++; $display("FAIL addi_instr got=%h want=fff00093", out_instr); end
        $display("addi: instr=%h src=%b imm=%h", out_instr, out_immSrc, out_imm);
        in_valid = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL drain_valid got=%b want=0", out_valid); end
        n_cmp++; if (out_imm !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL drain_hold_imm got=%h want=ffffffff", out_imm); end
        $display("drain: valid=%b imm=%h", out_valid, out_imm);
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [4] = '{32'h00112623, 32'hFE000EE3, 32'h008000EF, 32'h123452B7};
        logic [2:0]  srcs  [4] = '{3'b001, 3'b010, 3'b011, 3'b100};
        logic [31:0] imms  [4] = '{32'h0000000C, 32'hFFFFFFFC, 32'h00000008, 32'h12345000};
        for (int i = 0; i < 4; i++) begin
            in_instr = words[i]; in_valid = 1'b1; out_ready = 1'b1;
            #1;
            n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready[%0d] got=%b want=1", i, in_ready); end
            @(posedge clk); #1;
            n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid[%0d] got=%b want=1", i, out_valid); end
            n_cmp++; if (out_immSrc !== srcs[i]) begin n_bad++; $display("FAIL b2b_src[%0d] got=%b want=%b", i, out_immSrc, srcs[i]); end
            n_cmp++; if (out_imm !== imms[i]) begin n_bad++; $display("FAIL b2b_imm[%0d] got=%h want=%h", i, out_imm, imms[i]); end
            $display("b2b[%0d]: instr=%h src=%b imm=%h", i, out_instr, out_immSrc, out_imm);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_other_formats();
        send(32'h002081B3);  // add x3,x1,x2
        n_cmp++; if (out_imm !== 32'd0 || out_immSrc !== 3'b000 || out_illegal !== 1'b0) begin
            n_bad++; $display("FAIL rtype got src=%b imm=%h ill=%b want 000/0/0", out_immSrc, out_imm, out_illegal); end
        $display("rtype: src=%b imm=%h ill=%b", out_immSrc, out_imm, out_illegal);
        send(32'hFFC08067);  // jalr x0,-4(x1)
        n_cmp++; if (out_imm !== 32'hFFFFFFFC || out_immSrc !== 3'b000) begin
            n_bad++; $display("FAIL jalr got src=%b imm=%h want 000/fffffffc", out_immSrc, out_imm); end
        $display("jalr: src=%b imm=%h", out_immSrc, out_imm);
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        send(32'h00112623);
        in_instr = 32'h008000EF; in_valid = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready[%0d] got=%b want=0", i, in_ready); end
            @(posedge clk); #1;
            n_cmp++; if (out_valid !== 1'b1 || out_immSrc !== 3'b001 || out_imm !== 32'h0000000C || out_instr !== 32'h00112623) begin
                n_bad++; $display("FAIL bp_hold[%0d] got v=%b src=%b imm=%h instr=%h want 1/001/0000000c/00112623",
                                  i, out_valid, out_immSrc, out_imm, out_instr); end
            $display("bp_hold[%0d]: v=%b src=%b imm=%h", i, out_valid, out_immSrc, out_imm);
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready got=%b want=1", in_ready); end
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b1 || out_immSrc !== 3'b011 || out_imm !== 32'h00000008 || out_instr !== 32'h008000EF) begin
            n_bad++; $display("FAIL bp_release got v=%b src=%b imm=%h instr=%h want 1/011/00000008/008000ef",
                              out_valid, out_immSrc, out_imm, out_instr); end
        $display("bp_release: instr=%h src=%b imm=%h", out_instr, out_immSrc, out_imm);
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_illegal();
        do_reset();
        send(32'h0000007F);
        n_cmp++; if (out_illegal !== 1'b1 || out_imm !== 32'd0 || out_immSrc !== 3'b000) begin
            n_bad++; $display("FAIL ill1 got ill=%b imm=%h src=%b want 1/0/000", out_illegal, out_imm, out_immSrc); end
        n_cmp++; if (illegal_cnt !== 8'd1) begin n_bad++; $display("FAIL ill1_cnt got=%0d want=1", illegal_cnt); end
        $display("ill1: ill=%b cnt=%0d", out_illegal, illegal_cnt);
        send(32'hFFFFFFFF);
        n_cmp++; if (out_illegal !== 1'b1 || out_imm !== 32'd0 || out_immSrc !== 3'b000) begin
            n_bad++; $display("FAIL ill2 got ill=%b imm=%h src=%b want 1/0/000", out_illegal, out_imm, out_immSrc); end
        n_cmp++; if (illegal_cnt !== 8'd2) begin n_bad++; $display("FAIL ill2_cnt got=%0d want=2", illegal_cnt); end
        $display("ill2: ill=%b cnt=%0d", out_illegal, illegal_cnt);
        send(32'hFFF00093);
        n_cmp++; if (out_illegal !== 1'b0 || illegal_cnt !== 8'd2) begin
            n_bad++; $display("FAIL legal_after got ill=%b cnt=%0d want 0/2", out_illegal, illegal_cnt); end
        $display("legal_after: ill=%b cnt=%0d", out_illegal, illegal_cnt);
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_cnt_saturate();
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            send(32'h0000007F);
            n_cmp++; if (illegal_cnt_c2 !== 2'((i > 3) ? 3 : i)) begin
                n_bad++; $display("FAIL sat_c2[%0d] got=%0d want=%0d", i, illegal_cnt_c2, (i > 3) ? 3 : i); end
            n_cmp++; if (illegal_cnt !== 8'(i)) begin
                n_bad++; $display("FAIL sat_main[%0d] got=%0d want=%0d", i, illegal_cnt, i); end
            $display("sat[%0d]: cnt2=%0d cnt8=%0d", i, illegal_cnt_c2, illegal_cnt);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        send(32'h00112623);
        in_instr = 32'h0000007F; in_valid = 1'b1; out_ready = 1'b0; flush = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_ready got=%b want=0", in_ready); end
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid got=%b want=0", out_valid); end
        n_cmp++; if (illegal_cnt !== 8'd0) begin n_bad++; $display("FAIL flush_cnt got=%0d want=0", illegal_cnt); end
        n_cmp++; if (out_instr !== 32'h00112623) begin n_bad++; $display("FAIL flush_drop got=%h want=00112623", out_instr); end
        $display("flush: v=%b instr=%h cnt=%0d", out_valid, out_instr, illegal_cnt);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        n_cmp++; if (out_valid !== 1'b0 || out_instr !== 32'h00112623) begin
            n_bad++; $display("FAIL flush_after got v=%b instr=%h want 0/00112623", out_valid, out_instr); end
        $display("flush_after: v=%b instr=%h", out_valid, out_instr);
    endtask

    task automatic test_reset_midtransfer();
        send(32'h008000EF);
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h0000007F; rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        n_cmp++; if (out_valid !== 1'b0 || out_instr !== 32'd0 || illegal_cnt !== 8'd0) begin
            n_bad++; $display("FAIL rst_mid got v=%b instr=%h cnt=%0d want 0/0/0", out_valid, out_instr, illegal_cnt); end
        $display("rst_mid: v=%b instr=%h cnt=%0d", out_valid, out_instr, illegal_cnt);
    endtask

    task automatic test_xlen64();
        do_reset();
        send(32'h800002B7);
        n_cmp++; if (out_imm_64 !== 64'hFFFFFFFF80000000) begin
            n_bad++; $display("FAIL x64_lui got=%h want=ffffffff80000000", out_imm_64); end
        n_cmp++; if (out_imm !== 32'h80000000 || out_immSrc_64 !== 3'b100) begin
            n_bad++; $display("FAIL x32_lui got imm=%h src64=%b want 80000000/100", out_imm, out_immSrc_64); end
        $display("x64_lui: imm64=%h imm32=%h", out_imm_64, out_imm);
        send(32'hFFF00093);
        n_cmp++; if (out_imm_64 !== 64'hFFFFFFFFFFFFFFFF) begin
            n_bad++; $display("FAIL x64_addi got=%h want=ffffffffffffffff", out_imm_64); end
        $display("x64_addi: imm64=%h", out_imm_64);
        send(32'h123452B7);
        n_cmp++; if (out_imm_64 !== 64'h0000000012345000) begin
            n_bad++; $display("FAIL x64_lui_pos got=%h want=0000000012345000", out_imm_64); end
        $display("x64_lui_pos: imm64=%h", out_imm_64);
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = 32'd0; out_ready = 1'b1;
        test_reset();
        test_addi();
        test_back_to_back();
        test_other_formats();
        test_backpressure();
        test_illegal();
        test_cnt_saturate();
        test_flush();
        test_reset_midtransfer();
        test_xlen64();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
